// File: rtl/execute_pipeline_stage.sv
// Execute stage: D/E register, 16-bit ALU and write-data select, E/M register. Optional flags via EXEC_FLAGS_EN.
// Latency: 2 clk edges from inputs to all outputs, one operation per cycle.
// Backpressure: none; the stage never stalls and never inserts bubbles.
module execute_pipeline_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_in,
    input  logic        wme_in,
    input  logic        mm_in,
    input  logic        wm_in,
    input  logic        am_in,
    input  logic        ni_in,
    input  logic [2:0]  aluop_in,
    input  logic [15:0] src_a_in,
    input  logic [15:0] src_b_in,
    output logic        wbs_out,
    output logic        wme_out,
    output logic        mm_out,
    output logic        wm_out,
    output logic        ni_out,
    output logic [15:0] alu_result_out,
    output logic [15:0] mem_data_out,
    output logic        flag_n_out,
    output logic        flag_z_out
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef struct packed {
        logic        wbs;
        logic        wme;
        logic        mm;
        logic        wm;
        logic        am;
        logic        ni;
        logic [2:0]  aluop;
        logic [15:0] src_a;
        logic [15:0] src_b;
    } de_t;

    typedef struct packed {
        logic        wbs;
        logic        wme;
        logic        mm;
        logic        wm;
        logic        ni;
        logic [15:0] alu_result;
        logic [15:0] mem_data;
    } em_t;

    de_t         de_d, de_q;
    em_t         em_d, em_q;
    logic [15:0] alu_result;

    always_comb begin
        de_d       = '0;
        de_d.wbs   = wbs_in;
        de_d.wme   = wme_in;
        de_d.mm    = mm_in;
        de_d.wm    = wm_in;
        de_d.am    = am_in;
        de_d.ni    = ni_in;
        de_d.aluop = aluop_in;
        de_d.src_a = src_a_in;
        de_d.src_b = src_b_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q <= '0;
        end else begin
            de_q <= de_d;
        end
    end

    // Carry and borrow fall off the top: plain 16-bit modulo arithmetic.
    always_comb begin
        alu_result = 16'h0000;
        case (de_q.aluop)
            OP_ADD:  alu_result = de_q.src_a + de_q.src_b;
            OP_SUB:  alu_result = de_q.src_a - de_q.src_b;
            OP_AND:  alu_result = de_q.src_a & de_q.src_b;
            OP_OR:   alu_result = de_q.src_a | de_q.src_b;
            OP_XOR:  alu_result = de_q.src_a ^ de_q.src_b;
            OP_SLL:  alu_result = de_q.src_a << de_q.src_b[3:0];
            OP_SRL:  alu_result = de_q.src_a >> de_q.src_b[3:0];
            OP_PASS: alu_result = de_q.src_b;
            default: alu_result = 16'h0000;
        endcase
    end

    // am and aluop end here; only the write data select depends on am.
    always_comb begin
        em_d            = '0;
        em_d.wbs        = de_q.wbs;
        em_d.wme        = de_q.wme;
        em_d.mm         = de_q.mm;
        em_d.wm         = de_q.wm;
        em_d.ni         = de_q.ni;
        em_d.alu_result = alu_result;
        em_d.mem_data   = de_q.am ? de_q.src_b : 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_q <= '0;
        end else begin
            em_q <= em_d;
        end
    end

    assign wbs_out        = em_q.wbs;
    assign wme_out        = em_q.wme;
    assign mm_out         = em_q.mm;
    assign wm_out         = em_q.wm;
    assign ni_out         = em_q.ni;
    assign alu_result_out = em_q.alu_result;
    assign mem_data_out   = em_q.mem_data;

`ifdef EXEC_FLAGS_EN
    logic flag_n_q;
    logic flag_z_q;

    // Z reads 0 in reset because it is the flop value, not a live compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            flag_n_q <= alu_result[15];
            flag_z_q <= (alu_result == 16'h0000);
        end
    end

    assign flag_n_out = flag_n_q;
    assign flag_z_out = flag_z_q;
`else
    assign flag_n_out = 1'b0;
    assign flag_z_out = 1'b0;
`endif

endmodule

// File: tb/tb_execute_pipeline_stage.sv
// Directed bench for execute_pipeline_stage: reset behaviour, every ALU op, back-to-back streaming, mid-flight reset.
module tb_execute_pipeline_stage;

    logic        clk;
    logic        rst_n;
    logic        wbs_in, wme_in, mm_in, wm_in, am_in, ni_in;
    logic [2:0]  aluop_in;
    logic [15:0] src_a_in, src_b_in;
    logic        wbs_out, wme_out, mm_out, wm_out, ni_out;
    logic [15:0] alu_result_out, mem_data_out;
    logic        flag_n_out, flag_z_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        am;
        logic [4:0]  ctl;
        logic [15:0] res;
        logic [15:0] mem;
        logic        n;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    execute_pipeline_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wbs_in         (wbs_in),
        .wme_in         (wme_in),
        .mm_in          (mm_in),
        .wm_in          (wm_in),
        .am_in          (am_in),
        .ni_in          (ni_in),
        .aluop_in       (aluop_in),
        .src_a_in       (src_a_in),
        .src_b_in       (src_b_in),
        .wbs_out        (wbs_out),
        .wme_out        (wme_out),
        .mm_out         (mm_out),
        .wm_out         (wm_out),
        .ni_out         (ni_out),
        .alu_result_out (alu_result_out),
        .mem_data_out   (mem_data_out),
        .flag_n_out     (flag_n_out),
        .flag_z_out     (flag_z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic flag_exp(input logic f);
`ifdef EXEC_FLAGS_EN
        return f;
`else
        return 1'b0;
`endif
    endfunction

    task automatic add_vec(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic am, input logic [4:0] ctl, input logic [15:0] res,
                           input logic [15:0] mem, input logic n, input logic z);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.am = am; v.ctl = ctl;
        v.res = res; v.mem = mem; v.n = n; v.z = z;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        {wbs_in, wme_in, mm_in, wm_in, ni_in} = v.ctl;
        am_in    = v.am;
        aluop_in = v.op;
        src_a_in = v.a;
        src_b_in = v.b;
    endtask

    task automatic check_zero(input string tag, input bit with_z);
        check({tag, "_res"}, alu_result_out, 16'h0000);
        check({tag, "_mem"}, mem_data_out, 16'h0000);
        check({tag, "_ctl"}, {11'd0, wbs_out, wme_out, mm_out, wm_out, ni_out}, 16'h0000);
        check({tag, "_n"}, {15'd0, flag_n_out}, 16'h0000);
        if (with_z) check({tag, "_z"}, {15'd0, flag_z_out}, 16'h0000);
    endtask

    task automatic check_vec(input int k);
        vec_t v;
        v = vecs[k];
        check($sformatf("res%0d", k), alu_result_out, v.res);
        check($sformatf("mem%0d", k), mem_data_out, v.mem);
        check($sformatf("ctl%0d", k), {11'd0, wbs_out, wme_out, mm_out, wm_out, ni_out}, {11'd0, v.ctl});
        check($sformatf("n%0d", k), {15'd0, flag_n_out}, {15'd0, flag_exp(v.n)});
        check($sformatf("z%0d", k), {15'd0, flag_z_out}, {15'd0, flag_exp(v.z)});
    endtask

    initial begin
        //        op      a        b        am    ctl       res      mem      n     z
        add_vec(3'b001, 16'h0002, 16'h0003, 1'b0, 5'b11111, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        add_vec(3'b010, 16'hF0F0, 16'h0F0F, 1'b1, 5'b00000, 16'h0000, 16'h0F0F, 1'b0, 1'b1);
        add_vec(3'b011, 16'h5555, 16'hAAAA, 1'b1, 5'b11111, 16'hFFFF, 16'hAAAA, 1'b1, 1'b0);
        add_vec(3'b000, 16'hFFFF, 16'h0001, 1'b0, 5'b10101, 16'h0000, 16'h0000, 1'b0, 1'b1);
        add_vec(3'b101, 16'h8001, 16'h0001, 1'b1, 5'b01010, 16'h0002, 16'h0001, 1'b0, 1'b0);
        add_vec(3'b100, 16'h1234, 16'hFFFF, 1'b0, 5'b11000, 16'hEDCB, 16'h0000, 1'b1, 1'b0);
        add_vec(3'b110, 16'h8000, 16'h000F, 1'b1, 5'b00111, 16'h0001, 16'h000F, 1'b0, 1'b0);
        add_vec(3'b111, 16'h1111, 16'h8765, 1'b1, 5'b10011, 16'h8765, 16'h8765, 1'b1, 1'b0);
        add_vec(3'b101, 16'h0001, 16'h0010, 1'b0, 5'b01100, 16'h0001, 16'h0000, 1'b0, 1'b0);
        add_vec(3'b000, 16'h7FFF, 16'h0001, 1'b0, 5'b00001, 16'h8000, 16'h0000, 1'b1, 1'b0);

        // Reset held with nonzero inputs while the clock runs.
        rst_n = 1'b0;
        drive(vecs[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero($sformatf("rst_hold%0d", i), 1'b1);
        end

        // Release between edges; outputs stay 0 until the 2nd edge after release.
        drive(vecs[2]);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("rel_edge1", 1'b0);
        @(negedge clk);
        check_vec(2);

        // Back-to-back stream of every vector.
        for (int i = 0; i < vecs.size() + 2; i++) begin
            @(negedge clk);
            if (i >= 2) check_vec(i - 2);
            if (i < vecs.size()) drive(vecs[i]);
        end

        // Reset asserted mid-flight, away from any edge, clears outputs at once.
        @(negedge clk);
        drive(vecs[0]);
        @(negedge clk);
        drive(vecs[1]);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst", 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(vecs[7]);
        @(negedge clk);
        check_zero("mid_rel_edge1", 1'b0);
        @(negedge clk);
        check_vec(7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
